// File: rtl/ins_encoder_if.sv
// ins_encoder_if: request and encoded-word stream bundle.
// master drives requests and ins_ready; slave is the encoder.
interface ins_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_kind;
  logic [2:0]  req_funct3;
  logic        req_alt;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic        ins_last;
  logic        err;

  modport master (
    output req_valid, req_kind, req_funct3, req_alt,
    output req_rd, req_rs1, req_rs2, req_imm,
    output ins_ready,
    input  req_ready, ins_valid, ins, ins_last, err
  );

  modport slave (
    input  req_valid, req_kind, req_funct3, req_alt,
    input  req_rd, req_rs1, req_rs2, req_imm,
    input  ins_ready,
    output req_ready, ins_valid, ins, ins_last, err
  );
endinterface

// File: rtl/ins_encoder.sv
// ins_encoder: field requests -> RV32I words, LI expansion.
// Ports: clk, rst (sync high), bus (slave: req in, ins out, err).
module ins_encoder (
  input logic clk,
  input logic rst,
  ins_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    HOLD_HI
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] ins_q;
  logic [31:0] lo_q;
  logic        last_q;
  logic        err_q;

  logic        accept;
  logic        bad;
  logic        two;
  logic [31:0] w0;
  logic [31:0] w1;

  logic [31:0] imm;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  f7;
  logic        sx12;
  logic        sx13;
  logic        sx21;
  logic        shift;
  logic [19:0] li_hi;

  logic k_op, k_opi, k_ld, k_st, k_br, k_lui;
  logic k_aui, k_jal, k_jalr, k_fen, k_sys, k_li;

  assign imm   = bus.req_imm;
  assign f3    = bus.req_funct3;
  assign rd    = bus.req_rd;
  assign rs1   = bus.req_rs1;
  assign rs2   = bus.req_rs2;
  assign f7    = bus.req_alt ? 7'h20 : 7'h00;
  assign sx12  = (&imm[31:11]) | ~(|imm[31:11]);
  assign sx13  = (&imm[31:12]) | ~(|imm[31:12]);
  assign sx21  = (&imm[31:20]) | ~(|imm[31:20]);
  assign shift = (f3 == 3'd1) || (f3 == 3'd5);
  // (imm + 0x800)[31:12]: round up when the low part is negative
  assign li_hi = imm[31:12] + {19'd0, imm[11]};

  assign k_op   = bus.req_kind == 4'd0;
  assign k_opi  = bus.req_kind == 4'd1;
  assign k_ld   = bus.req_kind == 4'd2;
  assign k_st   = bus.req_kind == 4'd3;
  assign k_br   = bus.req_kind == 4'd4;
  assign k_lui  = bus.req_kind == 4'd5;
  assign k_aui  = bus.req_kind == 4'd6;
  assign k_jal  = bus.req_kind == 4'd7;
  assign k_jalr = bus.req_kind == 4'd8;
  assign k_fen  = bus.req_kind == 4'd9;
  assign k_sys  = bus.req_kind == 4'd10;
  assign k_li   = bus.req_kind == 4'd11;

  always_comb begin
    bad = 1'b0;
    two = 1'b0;
    w0  = 32'd0;
    w1  = {imm[11:0], rd, 3'd0, rd, 7'h13};
    unique case (1'b1)
      k_op: begin
        bad = bus.req_alt && f3 != 3'd0 && f3 != 3'd5;
        w0  = {f7, rs2, rs1, f3, rd, 7'h33};
      end
      k_opi: begin
        bad = (bus.req_alt && f3 != 3'd5)
            || (shift ? |imm[31:5] : !sx12);
        w0  = shift ? {f7, imm[4:0], rs1, f3, rd, 7'h13}
                    : {imm[11:0], rs1, f3, rd, 7'h13};
      end
      k_ld: begin
        bad = !sx12 || f3 == 3'd3 || f3[2:1] == 2'b11;
        w0  = {imm[11:0], rs1, f3, rd, 7'h03};
      end
      k_st: begin
        bad = !sx12 || f3 > 3'd2;
        w0  = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
      end
      k_br: begin
        bad = !sx13 || imm[0] || f3[2:1] == 2'b01;
        w0  = {imm[12], imm[10:5], rs2, rs1, f3,
               imm[4:1], imm[11], 7'h63};
      end
      k_lui: begin
        bad = |imm[11:0];
        w0  = {imm[31:12], rd, 7'h37};
      end
      k_aui: begin
        bad = |imm[11:0];
        w0  = {imm[31:12], rd, 7'h17};
      end
      k_jal: begin
        bad = !sx21 || imm[0];
        w0  = {imm[20], imm[10:1], imm[11],
               imm[19:12], rd, 7'h6f};
      end
      k_jalr: begin
        bad = !sx12;
        w0  = {imm[11:0], rs1, 3'd0, rd, 7'h67};
      end
      k_fen: w0 = 32'h0ff0000f;
      k_sys: w0 = imm[0] ? 32'h00100073 : 32'h00000073;
      k_li: begin
        if (sx12) begin
          w0 = {imm[11:0], 5'd0, 3'd0, rd, 7'h13};
        end else begin
          w0  = {li_hi, rd, 7'h37};
          two = |imm[11:0];
        end
      end
      default: bad = 1'b1;
    endcase
  end

  assign accept = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (accept && !bad) begin
      state_nx = two ? HOLD_HI : HOLD;
    end else begin
      unique case (state)
        IDLE:    state_nx = IDLE;
        HOLD:    if (bus.ins_ready) state_nx = IDLE;
        HOLD_HI: if (bus.ins_ready) state_nx = HOLD;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.ins_valid = 1'b0;
    unique case (state)
      IDLE: bus.req_ready = 1'b1;
      HOLD: begin
        bus.ins_valid = 1'b1;
        bus.req_ready = bus.ins_ready;
      end
      HOLD_HI: bus.ins_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ins_q  <= 32'd0;
      lo_q   <= 32'd0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= accept && bad;
      if (accept && !bad) begin
        ins_q  <= w0;
        lo_q   <= w1;
        last_q <= !two;
      end else if (state == HOLD_HI && bus.ins_ready) begin
        ins_q  <= lo_q;
        last_q <= 1'b1;
      end
    end
  end

  assign bus.ins      = ins_q;
  assign bus.ins_last = last_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ins_encoder.sv
// tb_ins_encoder: random + directed bench for ins_encoder
// against a queue-based reference model.
module tb_ins_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ins_encoder_if bus ();

  ins_encoder dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;
  bit rand_mode = 1'b0;

  logic [32:0] q[$];
  bit err_exp = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] i_fmt(
    input logic [31:0] im, input logic [31:0] s1,
    input logic [31:0] fn, input logic [31:0] d,
    input logic [31:0] op);
    return ((im & 32'hfff) << 20) | (s1 << 15) | (fn << 12)
         | (d << 7) | op;
  endfunction

  function automatic logic [31:0] s_fmt(
    input logic [31:0] im, input logic [31:0] s1,
    input logic [31:0] s2, input logic [31:0] fn);
    return (((im >> 5) & 32'h7f) << 25) | (s2 << 20)
         | (s1 << 15) | (fn << 12) | ((im & 32'h1f) << 7)
         | 32'h23;
  endfunction

  function automatic logic [31:0] b_fmt(
    input logic [31:0] im, input logic [31:0] s1,
    input logic [31:0] s2, input logic [31:0] fn);
    return (((im >> 12) & 1) << 31)
         | (((im >> 5) & 32'h3f) << 25) | (s2 << 20)
         | (s1 << 15) | (fn << 12) | (((im >> 1) & 32'hf) << 8)
         | (((im >> 11) & 1) << 7) | 32'h63;
  endfunction

  function automatic logic [31:0] j_fmt(
    input logic [31:0] im, input logic [31:0] d);
    return (((im >> 20) & 1) << 31)
         | (((im >> 1) & 32'h3ff) << 21)
         | (((im >> 11) & 1) << 20)
         | (((im >> 12) & 32'hff) << 12) | (d << 7) | 32'h6f;
  endfunction

  // Reference: what the encoder must produce for one request.
  function automatic void ref_enc(
    input int kind, input int fn, input bit alt,
    input int d, input int s1, input int s2,
    input logic [31:0] imm,
    output bit bad, output int n,
    output logic [31:0] w0, output logic [31:0] w1);
    int s;
    bit f12, f13, f21, sh;
    logic [31:0] lo, hi;
    s   = $signed(imm);
    f12 = s >= -2048 && s <= 2047;
    f13 = s >= -4096 && s <= 4095;
    f21 = s >= -(1 << 20) && s < (1 << 20);
    sh  = fn == 1 || fn == 5;
    bad = 1'b0;
    n   = 1;
    w0  = 32'd0;
    w1  = 32'd0;
    case (kind)
      0: begin
        bad = alt && fn != 0 && fn != 5;
        w0 = (alt ? 32'h40000000 : 32'd0) | (s2 << 20)
           | (s1 << 15) | (fn << 12) | (d << 7) | 32'h33;
      end
      1: begin
        bad = (alt && fn != 5) || (sh ? imm > 31 : !f12);
        if (sh) w0 = i_fmt((alt ? 32'h400 : 32'd0)
                           | (imm & 31), s1, fn, d, 32'h13);
        else    w0 = i_fmt(imm, s1, fn, d, 32'h13);
      end
      2: begin
        bad = !f12 || fn == 3 || fn == 6 || fn == 7;
        w0 = i_fmt(imm, s1, fn, d, 32'h03);
      end
      3: begin
        bad = !f12 || fn > 2;
        w0 = s_fmt(imm, s1, s2, fn);
      end
      4: begin
        bad = !f13 || imm[0] || fn == 2 || fn == 3;
        w0 = b_fmt(imm, s1, s2, fn);
      end
      5, 6: begin
        bad = (imm & 32'hfff) != 0;
        w0 = (imm & 32'hfffff000) | (d << 7)
           | (kind == 5 ? 32'h37 : 32'h17);
      end
      7: begin
        bad = !f21 || imm[0];
        w0 = j_fmt(imm, d);
      end
      8: begin
        bad = !f12;
        w0 = i_fmt(imm, s1, 0, d, 32'h67);
      end
      9:  w0 = 32'h0ff0000f;
      10: w0 = imm[0] ? 32'h00100073 : 32'h00000073;
      11: begin
        if (f12) begin
          w0 = i_fmt(imm, 0, 0, d, 32'h13);
        end else begin
          hi = (imm + 32'h800) & 32'hfffff000;
          lo = imm & 32'hfff;
          w0 = hi | (d << 7) | 32'h37;
          if (lo != 0) begin
            n  = 2;
            w1 = i_fmt(lo, d, 0, d, 32'h13);
          end
        end
      end
      default: begin
        bad = 1'b1;
        n   = 0;
      end
    endcase
  endfunction

  // Compare and model step on every falling edge.
  always @(negedge clk) begin
    bit rdy_exp;
    bit bad;
    int n;
    logic [31:0] w0, w1;
    rdy_exp = q.size() == 0 || (q.size() == 1 && bus.ins_ready);
    if (armed) begin
      check("ins_valid", {31'd0, bus.ins_valid},
            {31'd0, q.size() != 0});
      if (q.size() != 0) begin
        check("ins", bus.ins, q[0][31:0]);
        check("ins_last", {31'd0, bus.ins_last}, {31'd0, q[0][32]});
      end
      check("req_ready", {31'd0, bus.req_ready}, {31'd0, rdy_exp});
      check("err", {31'd0, bus.err}, {31'd0, err_exp});
    end
    if (rst) begin
      q.delete();
      err_exp = 1'b0;
      armed   = 1'b1;
    end else if (armed) begin
      err_exp = 1'b0;
      if (q.size() != 0 && bus.ins_ready) void'(q.pop_front());
      if (bus.req_valid && rdy_exp) begin
        ref_enc(int'(bus.req_kind), int'(bus.req_funct3),
                bus.req_alt, int'(bus.req_rd), int'(bus.req_rs1),
                int'(bus.req_rs2), bus.req_imm, bad, n, w0, w1);
        err_exp = bad;
        if (!bad) begin
          q.push_back({n == 1, w0});
          if (n == 2) q.push_back({1'b1, w1});
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) bus.ins_ready = ($urandom % 4) != 0;
    end
  end

  // Called at posedge+1; returns at posedge(accept)+1.
  task automatic send(input int k, input int fn, input bit alt,
                      input int d, input int s1, input int s2,
                      input logic [31:0] imm);
    bit ok;
    bus.req_valid  = 1'b1;
    bus.req_kind   = 4'(k);
    bus.req_funct3 = 3'(fn);
    bus.req_alt    = alt;
    bus.req_rd     = 5'(d);
    bus.req_rs1    = 5'(s1);
    bus.req_rs2    = 5'(s2);
    bus.req_imm    = imm;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 7)
      0: return 32'($urandom_range(0, 4095)) - 32'd2048;
      1: return 32'($urandom_range(0, 40));
      2: return r & 32'hfffff000;
      3: return r;
      4: return (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      5: return (32'($urandom_range(0, 32'h1fffff)) - 32'h100000)
                & ~32'd1;
      default: return 32'($urandom_range(0, 8191)) - 32'd4096;
    endcase
  endfunction

  initial begin
    bit bad;
    int n;
    logic [31:0] w0, w1;

    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    int n;
    logic [31:0] w0, w1;

    bus.req_valid  = 1'b0;
    bus.req_kind   = 4'd0;
    bus.req_funct3 = 3'd0;
    bus.req_alt    = 1'b0;
    bus.req_rd     = 5'd0;
    bus.req_rs1    = 5'd0;
    bus.req_rs2    = 5'd0;
    bus.req_imm    = 32'd0;
    bus.ins_ready  = 1'b1;

    ref_enc(0, 0, 0, 3, 1, 2, 32'd0, bad, n, w0, w1);
    check("m_op", w0, 32'h002081b3);
    ref_enc(4, 0, 0, 0, 1, 2, 32'd8, bad, n, w0, w1);
    check("m_br", w0, 32'h00208463);
    ref_enc(4, 0, 0, 0, 1, 2, 32'd3, bad, n, w0, w1);
    check("m_br_bad", {31'd0, bad}, 32'd1);
    ref_enc(11, 0, 0, 5, 0, 0, 32'h12345fff, bad, n, w0, w1);
    check("m_li2_hi", w0, 32'h123462b7);
    check("m_li2_lo", w1, 32'hfff28293);
    ref_enc(11, 0, 0, 1, 0, 0, 32'hfffffffb, bad, n, w0, w1);
    check("m_li_neg", w0, 32'hffb00093);
    ref_enc(11, 0, 0, 2, 0, 0, 32'h00010000, bad, n, w0, w1);
    check("m_li_lui", w0, 32'h00010137);
    check("m_li_n", 32'(n), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, bus.ins_valid}, 32'd0);
    check("rst_ins", bus.ins, 32'd0);
    check("rst_last", {31'd0, bus.ins_last}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;

    send(0, 0, 0, 3, 1, 2, 32'd0);
    @(negedge clk);
    check("op_valid", {31'd0, bus.ins_valid}, 32'd1);
    check("op_ins", bus.ins, 32'h002081b3);
    check("op_last", {31'd0, bus.ins_last}, 32'd1);
    @(posedge clk);
    #1;

    send(4, 0, 0, 0, 1, 2, 32'd8);
    @(negedge clk);
    check("br_ins", bus.ins, 32'h00208463);
    @(posedge clk);
    #1;
    send(4, 0, 0, 0, 1, 2, 32'd3);
    @(negedge clk);
    check("br_err", {31'd0, bus.err}, 32'd1);
    check("br_novalid", {31'd0, bus.ins_valid}, 32'd0);
    @(negedge clk);
    check("br_err_pulse", {31'd0, bus.err}, 32'd0);
    @(posedge clk);
    #1;

    send(11, 0, 0, 5, 0, 0, 32'h12345fff);
    @(negedge clk);
    check("li_w0", bus.ins, 32'h123462b7);
    check("li_w0_last", {31'd0, bus.ins_last}, 32'd0);
    check("li_w0_rdy", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("li_w1", bus.ins, 32'hfff28293);
    check("li_w1_last", {31'd0, bus.ins_last}, 32'd1);
    @(posedge clk);
    #1;
    send(11, 0, 0, 1, 0, 0, 32'hfffffffb);
    @(negedge clk);
    check("li_neg", bus.ins, 32'hffb00093);
    @(posedge clk);
    #1;
    send(11, 0, 0, 2, 0, 0, 32'h00010000);
    @(negedge clk);
    check("li_lui", bus.ins, 32'h00010137);
    check("li_lui_last", {31'd0, bus.ins_last}, 32'd1);
    @(posedge clk);
    #1;

    bus.ins_ready = 1'b0;
    send(0, 0, 0, 3, 1, 2, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("bp_ins", bus.ins, 32'h002081b3);
      check("bp_rdy", {31'd0, bus.req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.ins_ready = 1'b1;
    send(0, 0, 1, 4, 5, 6, 32'd0);
    @(negedge clk);
    check("b2b_ins", bus.ins, 32'h40628233);
    check("b2b_valid", {31'd0, bus.ins_valid}, 32'd1);
    @(posedge clk);
    #1;

    bus.ins_ready = 1'b0;
    send(11, 0, 0, 5, 0, 0, 32'h12345fff);
    @(negedge clk);
    check("rli_hi", bus.ins, 32'h123462b7);
    @(posedge clk);
    #1;
    bus.ins_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.ins_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rli_valid", {31'd0, bus.ins_valid}, 32'd0);
    check("rli_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.ins_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(0, 0, 0, 3, 1, 2, 32'd0);
    @(negedge clk);
    check("rli_next", bus.ins, 32'h002081b3);
    @(posedge clk);
    #1;

    rand_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      int k;
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
      k = ($urandom % 8 == 0) ? int'($urandom_range(12, 15))
                              : int'($urandom_range(0, 11));
      send(k, int'($urandom_range(0, 7)), ($urandom % 3) == 0,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), rand_imm());
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.ins_ready = 1'b1;
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ins_encoder.md
Name: ins_encoder

Overview:
- Inverse of the instruction decoder: accepts field-level instruction requests (kind, funct3, registers, immediate) over a valid/ready handshake.
- Emits encoded RV32I instruction words on a registered valid/ready output stream.
- Validates immediate ranges and funct3 legality per kind.
- Expands the LI pseudo-instruction into ADDI, LUI, or LUI+ADDI.
- Used by the debug instruction injector and self-test program generator.

Parameters:
- None. Width fixed at 32-bit RV32I.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&&req_ready
- req_kind  in  4  0 OP, 1 OP_IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 FENCE, 10 SYSTEM, 11 LI; 12-15 illegal
- req_funct3  in  3  funct3 for OP/OP_IMM/LOAD/STORE/BRANCH; ignored otherwise
- req_alt  in  1  selects funct7=0100000 (SUB/SRA/SRAI)
- req_rd  in  5  destination register
- req_rs1  in  5  source register 1
- req_rs2  in  5  source register 2
- req_imm  in  32  byte-offset / value immediate; for SYSTEM, bit0=1 selects EBREAK
- ins_valid  out  1  ins holds a word
- ins_ready  in  1  consumer accepts word
- ins  out  32  encoded instruction
- ins_last  out  1  word is the final word of its request
- err  out  1  one-cycle pulse: previous accepted request was rejected

Behaviour:
- Reset: ins_valid=0, ins=0, ins_last=0, err=0, FSM=IDLE. req_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation discards the output register and any pending second LI word.
- FSM states:
  - IDLE: output register empty.
  - HOLD: word held. Exits on ins_ready. If ins_last, goes to IDLE, or reloads directly when a new request is accepted in the same cycle.
  - HOLD_HI: LUI of a two-word LI is held. On ins_ready, loads ADDI rd,rd,lo into the output register, sets ins_last=1, goes to HOLD.
- req_ready = IDLE || (HOLD && ins_ready). It is never asserted in HOLD_HI. Throughput is one word per cycle.
- Latency: a request accepted in cycle N yields ins_valid in N+1. ins and ins_last stay stable while ins_valid && !ins_ready.
- Encoding follows standard RV32I formats:
  - I-type: imm[11:0].
  - S-type: imm[11:5] / imm[4:0].
  - B-type: imm[12|10:5], imm[4:1|11].
  - U-type: imm[31:12].
  - J-type: imm[20|10:1|11|19:12].
  - FENCE: 0x0FF0000F.
  - ECALL: 0x00000073. EBREAK: 0x00100073.
- Validation rejects a request when any of the following holds:
  - kind 12-15.
  - I/S imm not a sign-extended 12-bit value.
  - B imm not a 13-bit signed value, or odd.
  - J imm not a 21-bit signed value, or odd.
  - LUI/AUIPC imm[11:0] != 0.
  - OP_IMM shift (funct3 1/5) with imm >31.
  - OP_IMM req_alt with funct3 != 5.
  - OP req_alt with funct3 not in {0,5}.
  - LOAD funct3 in {3,6,7}.
  - STORE funct3 >2.
  - BRANCH funct3 in {2,3}.
- Rejected request handling: the request is still accepted, no word is emitted, the output register is unchanged/empty, and err=1 for exactly the cycle after acceptance.
- LI expansion:
  - imm in [-2048,2047]: single ADDI rd,x0,imm.
  - Otherwise hi=(imm+0x800)[31:12] with 32-bit wraparound, lo=imm[11:0].
  - lo==0: single LUI rd,hi.
  - lo!=0: LUI (ins_last=0) then ADDI rd,rd,lo (ins_last=1).
  - LI never sets err.
- rd=x0 is legal and encoded verbatim.

Test Plan:
- Stream encoding: OP funct3=0 rd=3 rs1=1 rs2=2, with ins_ready held 1 -> ins=0x002081B3, ins_last=1, ins_valid one cycle after acceptance.
- Branch encode and reject: BRANCH funct3=0 rs1=1 rs2=2 imm=8 -> 0x00208463. Same request with imm=3 -> err pulse, no ins_valid.
- LI two-word: LI rd=5 imm=0x12345FFF:
  - First word 0x123462B7 (ins_last=0).
  - Then 0xFFF28293 (ins_last=1).
  - req_ready=0 between the two words.
- LI single-word: LI rd=1 imm=-5 -> single 0xFFB00093. LI rd=2 imm=0x00010000 -> single 0x00010137.
- Backpressure: hold ins_ready=0 for 3 cycles after ins_valid -> ins constant, req_ready=0. A back-to-back request is accepted in the same cycle as the ins_ready=1 handshake, with no bubble.
- Reset mid-LI: assert rst the cycle after the LUI handshake -> next cycle ins_valid=0 and ADDI never appears. The next request then encodes normally.
